// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// Module      : graphics_pkg
// Description : Shared geometry types and widths for the primitive pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package graphics_pkg;

    localparam int INDEX_WIDTH          = 12;
    localparam int DEFAULT_TRI_ID_WIDTH = 16;

    typedef logic [2:0][31:0] vec3_t;
    typedef vec3_t [2:0]      tri_pos_t;

endpackage
`default_nettype wire

// File: rtl/triangle_assembly.sv
`default_nettype none
// ============================================================================
// Module      : triangle_assembly
// Description : Groups consecutive vertices into triangles, flags degenerates.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_assembly
    import graphics_pkg::*;
#(
    parameter bit DROP_DEGENERATE = 1'b0,
    parameter int ID_WIDTH        = DEFAULT_TRI_ID_WIDTH
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         frame_start_in,
    input  logic                         valid_in,
    input  logic [2:0][31:0]             position_in,
    input  logic [INDEX_WIDTH-1:0]       normal_in,
    input  logic [INDEX_WIDTH-1:0]       material_in,
    output logic                         valid_out,
    output logic [2:0][2:0][31:0]        position_out,
    output logic [INDEX_WIDTH-1:0]       normal_out,
    output logic [INDEX_WIDTH-1:0]       material_out,
    output logic                         degenerate_out,
    output logic [ID_WIDTH-1:0]          triangle_id_out
);

    function automatic logic vec_eq(input vec3_t a, input vec3_t b);
        return (a == b);
    endfunction

    logic [1:0]             r_vcnt;
    logic [ID_WIDTH-1:0]    r_tid;
    vec3_t                  r_slot_a_pos;
    vec3_t                  r_slot_b_pos;
    logic [INDEX_WIDTH-1:0] r_slot_a_normal;
    logic [INDEX_WIDTH-1:0] r_slot_a_material;

    logic                   w_store_a;
    logic                   w_store_b;
    logic                   w_complete;
    logic                   w_degenerate;

    // A frame start re-targets the incoming vertex to slot A of the new frame.
    always_comb begin
        w_store_a    = valid_in && (frame_start_in || r_vcnt == 2'd0);
        w_store_b    = valid_in && !frame_start_in && r_vcnt == 2'd1;
        w_complete   = valid_in && !frame_start_in && r_vcnt == 2'd2;
        w_degenerate = vec_eq(r_slot_a_pos, r_slot_b_pos)
                     | vec_eq(r_slot_b_pos, position_in)
                     | vec_eq(r_slot_a_pos, position_in);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vcnt            <= 2'd0;
            r_tid             <= '0;
            r_slot_a_pos      <= '0;
            r_slot_b_pos      <= '0;
            r_slot_a_normal   <= '0;
            r_slot_a_material <= '0;
            valid_out         <= 1'b0;
            position_out      <= '0;
            normal_out        <= '0;
            material_out      <= '0;
            degenerate_out    <= 1'b0;
            triangle_id_out   <= '0;
        end else begin
            valid_out <= 1'b0;

            if (frame_start_in) begin
                r_tid  <= '0;
                r_vcnt <= valid_in ? 2'd1 : 2'd0;
            end else if (valid_in) begin
                r_vcnt <= w_complete ? 2'd0 : r_vcnt + 2'd1;
            end

            if (w_store_a) begin
                r_slot_a_pos      <= position_in;
                r_slot_a_normal   <= normal_in;
                r_slot_a_material <= material_in;
            end

            if (w_store_b) begin
                r_slot_b_pos <= position_in;
            end

            // Dropped degenerates still consume an id to stay aligned with the index buffer.
            if (w_complete) begin
                position_out[0] <= r_slot_a_pos;
                position_out[1] <= r_slot_b_pos;
                position_out[2] <= position_in;
                normal_out      <= r_slot_a_normal;
                material_out    <= r_slot_a_material;
                degenerate_out  <= w_degenerate;
                triangle_id_out <= r_tid;
                r_tid           <= r_tid + 1'b1;
                valid_out       <= !(DROP_DEGENERATE && w_degenerate);
            end
        end
    end

endmodule
`default_nettype wire
